// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns engine: COLS_PER_CYCLE columns per clock over a shared GF(2^8) datapath.
// Optional MIXCOL_FWD_MODE_EN adds mode_in selecting the forward MixColumns matrix per block.
module inv_mix_columns_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
`ifdef MIXCOL_FWD_MODE_EN
   input  logic         mode_in,
`endif
   output logic         busy
);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   localparam int         NGROUPS  = 4 / COLS_PER_CYCLE;
   localparam logic [1:0] LAST_GRP = 2'(NGROUPS - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

   state_t       state_q, state_d;
   logic [1:0]   cnt_q, cnt_d;
   logic [127:0] work_q, work_d;
   logic [127:0] out_q, out_d;
   logic         in_ready_q, in_ready_d;
   logic         out_valid_q, out_valid_d;
   logic         busy_q, busy_d;
   logic         mode_q, mode_d;
   logic         fwd_s;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Both matrices share the xtime chain; the row rotation indexes the same product table.
   function automatic logic [31:0] mix_col(input logic [31:0] c, input logic fwd);
      logic [7:0]  a [4];
      logic [7:0]  x2 [4];
      logic [7:0]  x4 [4];
      logic [7:0]  x8 [4];
      logic [31:0] r_col;
      r_col = 32'h0;
      for (int r = 0; r < 4; r++) begin
         a[r]  = c[31-8*r -: 8];
         x2[r] = xtime(a[r]);
         x4[r] = xtime(x2[r]);
         x8[r] = xtime(x4[r]);
      end
      for (int r = 0; r < 4; r++) begin
         if (fwd) begin
            r_col[31-8*r -: 8] = x2[r] ^ (x2[(r+1)%4] ^ a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
         end else begin
            r_col[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                               ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                               ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                               ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
         end
      end
      return r_col;
   endfunction

`ifdef MIXCOL_FWD_MODE_EN
   assign fwd_s = mode_q;
`else
   assign fwd_s = 1'b0;
`endif

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 2'd0;
         work_q      <= 128'h0;
         out_q       <= 128'h0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         mode_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         work_q      <= work_d;
         out_q       <= out_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         mode_q      <= mode_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (in_valid)             state_d = S_CALC; else state_d = S_IDLE;
         S_CALC: if (cnt_q == LAST_GRP)    state_d = S_DONE; else state_d = S_CALC;
         S_DONE: if (out_ready)            state_d = S_IDLE; else state_d = S_DONE;
         default:                          state_d = S_IDLE;
      endcase
   end

   // Capture, in-place column transform and result latch at the final group.
   always_comb begin
      work_d = work_q;
      cnt_d  = cnt_q;
      out_d  = out_q;
      mode_d = mode_q;
      if (state_q == S_IDLE && in_valid) begin
         work_d = in_data;
         cnt_d  = 2'd0;
`ifdef MIXCOL_FWD_MODE_EN
         mode_d = mode_in;
`else
         mode_d = 1'b0;
`endif
      end else if (state_q == S_CALC) begin
         for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            work_d[127-32*(int'(cnt_q)*COLS_PER_CYCLE+k) -: 32] =
               mix_col(work_q[127-32*(int'(cnt_q)*COLS_PER_CYCLE+k) -: 32], fwd_s);
         end
         if (cnt_q == LAST_GRP) begin
            cnt_d = 2'd0;
            out_d = work_d;
         end else begin
            cnt_d = cnt_q + 2'd1;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Registered handshake/status outputs derived from the upcoming state.
   always_comb begin
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_data  = out_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: three instances (1, 2, 4 columns/cycle) share stimulus and are
// compared against a shift-and-add GF(2^8) matrix model.
module tb_inv_mix_columns_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [127:0] in_data;
   logic         out_ready;
   logic         mode_s;

   logic         ir1, ov1, bz1;
   logic         ir2, ov2, bz2;
   logic         ir4, ov4, bz4;
   logic [127:0] od1, od2, od4;

   int errors = 0;
   int checks = 0;

   localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] V2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
   localparam logic [127:0] E2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;

   always #5 clk = ~clk;

   inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
      .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
`ifdef MIXCOL_FWD_MODE_EN
      .mode_in(mode_s),
`endif
      .busy(bz1));
   inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
      .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
`ifdef MIXCOL_FWD_MODE_EN
      .mode_in(mode_s),
`endif
      .busy(bz2));
   inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
      .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
`ifdef MIXCOL_FWD_MODE_EN
      .mode_in(mode_s),
`endif
      .busy(bz4));

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      end
      return p;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] s, input logic fwd);
      logic [7:0]   m [4];
      logic [7:0]   a [4];
      logic [7:0]   b;
      logic [127:0] res = 128'h0;
      if (fwd) begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
      else     begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
         for (int r = 0; r < 4; r++) begin
            b = 8'h00;
            for (int j = 0; j < 4; j++) b = b ^ gmul(m[(j - r + 4) % 4], a[j]);
            res[127-32*c-8*r -: 8] = b;
         end
      end
      return res;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_dut(input string tag, input int lat, input int k, input logic ir,
                          input logic ov, input logic bz, input logic [127:0] od,
                          input logic [127:0] exp);
      check($sformatf("%s_valid_k%0d", tag, k), {127'h0, ov}, {127'h0, k == lat});
      check($sformatf("%s_busy_k%0d", tag, k), {127'h0, bz}, {127'h0, k <= lat});
      check($sformatf("%s_ready_k%0d", tag, k), {127'h0, ir}, {127'h0, k > lat});
      if (k == lat) check($sformatf("%s_data", tag), od, exp);
   endtask

   // Starts and ends on a falling edge with all instances idle and out_ready high.
   task automatic run_block(input string tag, input logic [127:0] d, input logic m,
                            input logic [127:0] exp);
      in_valid = 1'b1;
      in_data  = d;
      mode_s   = m;
      @(posedge clk);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) in_valid = 1'b0;
         chk_dut({tag, "_c1"}, 5, k, ir1, ov1, bz1, od1, exp);
         chk_dut({tag, "_c2"}, 3, k, ir2, ov2, bz2, od2, exp);
         chk_dut({tag, "_c4"}, 2, k, ir4, ov4, bz4, od4, exp);
      end
   endtask

   initial begin
      logic [127:0] rv;
      logic         rm;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 128'h0;
      out_ready = 1'b1;
      mode_s    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {127'h0, ir1}, 128'h0);
      check("rst_out_valid", {127'h0, ov1}, 128'h0);
      check("rst_out_data", od1, 128'h0);
      check("rst_busy", {127'h0, bz1}, 128'h0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", {127'h0, ir1 & ir2 & ir4}, 128'h1);
      check("model_v1", model(V1, 1'b0), E1);

      run_block("v1", V1, 1'b0, E1);
      run_block("v2", V2, 1'b0, E2);

      for (int i = 0; i < 8; i++) begin
         rv = {$urandom, $urandom, $urandom, $urandom};
`ifdef MIXCOL_FWD_MODE_EN
         rm = 1'($urandom_range(1, 0));
`else
         rm = 1'b0;
`endif
         run_block($sformatf("rnd%0d", i), rv, rm, model(rv, rm));
      end

      // Back-pressure: result held, new input ignored.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = V1;
      mode_s    = 1'b0;
      @(posedge clk);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) in_valid = 1'b0;
      end
      check("bp_valid_at_lat", {127'h0, ov1}, 128'h1);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = V2;
         @(negedge clk);
         check("bp_hold_valid", {127'h0, ov1 & ov2 & ov4}, 128'h1);
         check("bp_hold_ready", {127'h0, ir1 | ir2 | ir4}, 128'h0);
         check("bp_hold_data1", od1, E1);
         check("bp_hold_data4", od4, E1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", {127'h0, ov1 | ov2 | ov4}, 128'h0);
      check("bp_release_busy", {127'h0, bz1 | bz2 | bz4}, 128'h0);
      check("bp_release_ready", {127'h0, ir1 & ir2 & ir4}, 128'h1);
      check("bp_release_data", od1, E1);

      // Reset in the third CALC cycle of the 1-column instance.
      in_valid = 1'b1;
      in_data  = V2;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_valid", {127'h0, ov1 | ov2 | ov4}, 128'h0);
      check("midrst_busy", {127'h0, bz1 | bz2 | bz4}, 128'h0);
      check("midrst_data1", od1, 128'h0);
      check("midrst_data4", od4, 128'h0);
      check("midrst_ready", {127'h0, ir1}, 128'h0);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_ready_after", {127'h0, ir1}, 128'h1);
      run_block("post_rst_v1", V1, 1'b0, E1);

`ifdef MIXCOL_FWD_MODE_EN
      run_block("fwd", E1, 1'b1, V1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
